// File: rtl/seq_mac_ctrl_pkg.sv
// Shared types and widths for the streaming multiply-accumulate controller
// that fronts the 8x8 signed sequential shift-add multiplier.
package seq_mac_ctrl_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        ACC  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Signed add overflow: both addends share a sign that the sum does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/mac_accum.sv
// Signed accumulator: sign-extends each 16-bit product to ACC_W, adds with
// two's-complement wrap and keeps a sticky overflow flag until cleared.
module mac_accum
    import seq_mac_ctrl_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              add_en,
    input  logic              clr,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W-1:0] sum_s;
    logic             ovf_r;
    logic             ovf_add_s;

    assign prod_ext_s = ACC_W'($signed(product));
    assign sum_s      = acc_r + prod_ext_s;
    assign ovf_add_s  = add_ovf(acc_r[ACC_W-1], prod_ext_s[ACC_W-1], sum_s[ACC_W-1]);

    // Accumulator and sticky overflow; clear wins so a consumed sum restarts at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (add_en) begin
            acc_r <= sum_s;
            ovf_r <= ovf_r | ovf_add_s;
        end
    end

    assign acc = acc_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/seq_mac_ctrl.sv
// Streaming front end for the level-started sequential multiplier: accepts
// operand pairs, sequences start/ready per pair and emits the sum on "last".
module seq_mac_ctrl
    import seq_mac_ctrl_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_ready,
    input  logic [PROD_W-1:0] mul_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              err
);

    localparam int TC_W = $clog2(TIMEOUT + 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TC_W-1:0]   tcnt_r;
    logic              timeout_s;
    logic              accept_s;
    logic              run_exit_s;
    logic              acc_add_s;
    logic              acc_clr_s;
    logic              last_r;
    logic [PROD_W-1:0] prod_r;
    logic [OP_W-1:0]   mul_a_r;
    logic [OP_W-1:0]   mul_b_r;
    logic              in_ready_r;
    logic              mul_start_r;
    logic              out_valid_r;
    logic              err_r;
    logic              in_ready_nxt_s;
    logic              mul_start_nxt_s;
    logic              out_valid_nxt_s;

    assign accept_s   = (state_r == IDLE) && in_valid && in_ready_r;
    assign timeout_s  = (tcnt_r == TC_W'(TIMEOUT - 1));
    assign run_exit_s = (state_r == RUN) && (mul_ready || timeout_s);
    assign acc_add_s  = (state_r == ACC);
    assign acc_clr_s  = (state_r == OUT) && out_ready;

    // State register plus the handshake/start outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            mul_start_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            mul_start_r <= mul_start_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = LOAD;
                else          state_nxt_s = IDLE;
            end
            LOAD: state_nxt_s = RUN;
            RUN: begin
                if (run_exit_s) state_nxt_s = ACC;
                else            state_nxt_s = RUN;
            end
            ACC: begin
                if (last_r) state_nxt_s = OUT;
                else        state_nxt_s = IDLE;
            end
            OUT: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = OUT;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; start is high only in RUN so LOAD always separates two operations.
    always_comb begin
        in_ready_nxt_s  = (state_nxt_s == IDLE);
        mul_start_nxt_s = (state_nxt_s == RUN);
        out_valid_nxt_s = (state_nxt_s == OUT);
    end

    // Operand capture, RUN watchdog, product latch and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a_r <= {OP_W{1'b0}};
            mul_b_r <= {OP_W{1'b0}};
            last_r  <= 1'b0;
            tcnt_r  <= {TC_W{1'b0}};
            prod_r  <= {PROD_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                mul_a_r <= in_a;
                mul_b_r <= in_b;
                last_r  <= in_last;
            end
            if ((state_r == RUN) && !run_exit_s) begin
                tcnt_r <= tcnt_r + TC_W'(1);
            end else begin
                tcnt_r <= {TC_W{1'b0}};
            end
            // A timed-out multiply contributes zero to the sum.
            if (run_exit_s) begin
                prod_r <= mul_ready ? mul_product : {PROD_W{1'b0}};
            end
            if (run_exit_s && !mul_ready) begin
                err_r <= 1'b1;
            end else if (acc_clr_s) begin
                err_r <= 1'b0;
            end
        end
    end

    mac_accum #(
        .ACC_W(ACC_W)
    ) u_accum (
        .clk    (clk),
        .reset  (reset),
        .add_en (acc_add_s),
        .clr    (acc_clr_s),
        .product(prod_r),
        .acc    (acc_out),
        .ovf    (ovf)
    );

    assign in_ready  = in_ready_r;
    assign mul_start = mul_start_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign out_valid = out_valid_r;
    assign err       = err_r;

endmodule
